// File: rtl/alu_seq.sv
// alu_seq: multi-cycle ALU for the execute stage with a start/done handshake.
//
// Operations (gin): 010 ADD, 110 SUB, 111 SLT (signed), 000 AND, 001 OR,
// 101 SLL, 100 SRL (logical), 011 MUL (iterative, only with ALU_MUL_EN).
// ADD/SUB/SLT/AND/OR complete in one cycle. Shifts take amt+1 cycles.
// MUL takes WIDTH+1 cycles. Without ALU_MUL_EN, code 011 is illegal:
// it completes in one cycle with sum=0, status=3'b100, err=1.
//
// Build option: define ALU_MUL_EN to build the shift-add multiplier and its
// 2*WIDTH accumulator.
//
// Ports:
//   clk     rising-edge clock
//   reset   synchronous, active-high reset
//   start   request; accepted only while busy=0
//   gin     3-bit ALU control, sampled at accept
//   a, b    operands, sampled at accept
//   busy    multi-cycle operation in progress
//   done    one-cycle pulse; sum/status/err valid
//   sum     registered result, held until the next done
//   status  {zero, negative, overflow}, held with sum
//   err     illegal op on the last completed operation, held with sum
module alu_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       gin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic [2:0]       status,
    output logic             err
);

    localparam int unsigned SHW = $clog2(WIDTH);
    // Counter must hold WIDTH for the multiply as well as any shift amount
    localparam int unsigned CW  = SHW + 1;

    typedef enum logic [2:0] {
        OP_AND = 3'b000,
        OP_OR  = 3'b001,
        OP_ADD = 3'b010,
        OP_MUL = 3'b011,
        OP_SRL = 3'b100,
        OP_SLL = 3'b101,
        OP_SUB = 3'b110,
        OP_SLT = 3'b111
    } op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    op_e               op_q, op_d;
    logic [WIDTH-1:0]  acc_q, acc_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    logic [WIDTH-1:0]  sum_d;
    logic [2:0]        status_d;
    logic              err_d;
    logic              busy_d;
    logic              done_d;

    // Single-cycle datapath, evaluated on the live operands at accept
    logic [WIDTH-1:0]  add_res;
    logic [WIDTH-1:0]  sub_res;
    logic              ovf_add;
    logic              ovf_sub;
    logic              slt_bit;
    logic [SHW-1:0]    amt;
    logic [WIDTH-1:0]  shift_step;
    logic              is_mul;

    // Completion bundle gathered by the next-state logic
    logic [WIDTH-1:0]  res;
    logic              ovf;
    logic              fin;
    logic              ill;

    assign add_res    = a + b;
    assign sub_res    = a - b;
    assign ovf_add    = (a[WIDTH-1] == b[WIDTH-1]) && (add_res[WIDTH-1] != a[WIDTH-1]);
    assign ovf_sub    = (a[WIDTH-1] != b[WIDTH-1]) && (sub_res[WIDTH-1] != a[WIDTH-1]);
    assign slt_bit    = sub_res[WIDTH-1] ^ ovf_sub;
    assign amt        = b[SHW-1:0];
    assign shift_step = (op_q == OP_SLL) ? (acc_q << 1) : (acc_q >> 1);

`ifdef ALU_MUL_EN
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH:0]     mul_hi;
    logic [2*WIDTH-1:0] mul_step;

    // One shift-add iteration: add multiplicand into the high half when the
    // current multiplier bit (prod lsb) is set, then shift the pair right.
    assign mul_hi   = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, acc_q} : '0);
    assign mul_step = {mul_hi, prod_q[WIDTH-1:1]};
    assign is_mul   = (op_q == OP_MUL);
`else
    assign is_mul   = 1'b0;
`endif

    // Next-state and completion logic
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sum_d    = sum;
        status_d = status;
        err_d    = err;
        done_d   = 1'b0;
        busy_d   = 1'b0;
        res      = '0;
        ovf      = 1'b0;
        fin      = 1'b0;
        ill      = 1'b0;
`ifdef ALU_MUL_EN
        prod_d   = prod_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    op_d  = op_e'(gin);
                    acc_d = a;
                    case (op_e'(gin))
                        OP_ADD: begin
                            fin = 1'b1;
                            res = add_res;
                            ovf = ovf_add;
                        end
                        OP_SUB: begin
                            fin = 1'b1;
                            res = sub_res;
                            ovf = ovf_sub;
                        end
                        OP_SLT: begin
                            fin = 1'b1;
                            res = WIDTH'(slt_bit);
                        end
                        OP_AND: begin
                            fin = 1'b1;
                            res = a & b;
                        end
                        OP_OR: begin
                            fin = 1'b1;
                            res = a | b;
                        end
                        OP_SLL, OP_SRL: begin
                            if (amt == '0) begin
                                fin = 1'b1;
                                res = a;
                            end else begin
                                cnt_d   = CW'(amt);
                                state_d = ST_RUN;
                            end
                        end
                        OP_MUL: begin
`ifdef ALU_MUL_EN
                            prod_d  = {{WIDTH{1'b0}}, b};
                            cnt_d   = CW'(WIDTH);
                            state_d = ST_RUN;
`else
                            fin = 1'b1;
                            ill = 1'b1;
`endif
                        end
                    endcase
                end
            end

            ST_RUN: begin
                cnt_d = cnt_q - CW'(1);
                if (is_mul) begin
`ifdef ALU_MUL_EN
                    prod_d = mul_step;
                    if (cnt_q == CW'(1)) begin
                        fin = 1'b1;
                        res = mul_step[WIDTH-1:0];
                        ovf = |mul_step[2*WIDTH-1:WIDTH];
                    end
`endif
                end else begin
                    acc_d = shift_step;
                    if (cnt_q == CW'(1)) begin
                        fin = 1'b1;
                        res = shift_step;
                    end
                end
            end
        endcase

        // Status derives from the final result; an illegal op leaves res=0
        if (fin) begin
            state_d  = ST_IDLE;
            sum_d    = res;
            status_d = {(res == '0), res[WIDTH-1], ovf};
            err_d    = ill;
            done_d   = 1'b1;
        end

        busy_d = (state_d == ST_RUN);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_AND;
            acc_q   <= '0;
            cnt_q   <= '0;
            sum     <= '0;
            status  <= 3'b000;
            err     <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
`ifdef ALU_MUL_EN
            prod_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            sum     <= sum_d;
            status  <= status_d;
            err     <= err_d;
            busy    <= busy_d;
            done    <= done_d;
`ifdef ALU_MUL_EN
            prod_q  <= prod_d;
`endif
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed plus randomized checks of alu_seq against a
// behavioural model built from signed/unsigned arithmetic on wide integers.
module tb_alu_seq;

    localparam logic [2:0] ADD = 3'b010;
    localparam logic [2:0] SUB = 3'b110;
    localparam logic [2:0] SLT = 3'b111;
    localparam logic [2:0] AND = 3'b000;
    localparam logic [2:0] OR  = 3'b001;
    localparam logic [2:0] SLL = 3'b101;
    localparam logic [2:0] SRL = 3'b100;
    localparam logic [2:0] MUL = 3'b011;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  gin;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] sum;
    logic [2:0]  status;
    logic        err;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] prev_sum = '0;

    alu_seq #(.WIDTH(32)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .gin    (gin),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .sum    (sum),
        .status (status),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: true-arithmetic result, flags and latency for one operation
    function automatic void model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] r, output logic [2:0] st,
                                  output logic e, output int lat);
        longint      sx;
        longint      sy;
        longint      t;
        logic [63:0] p;
        logic        ov;
        int          sh;
        sx  = longint'($signed(x));
        sy  = longint'($signed(y));
        sh  = int'(y % 32);
        r   = '0;
        ov  = 1'b0;
        e   = 1'b0;
        lat = 1;
        case (op)
            ADD: begin
                t  = sx + sy;
                r  = t[31:0];
                ov = (t != longint'($signed(r)));
            end
            SUB: begin
                t  = sx - sy;
                r  = t[31:0];
                ov = (t != longint'($signed(r)));
            end
            SLT: r = (sx < sy) ? 32'd1 : 32'd0;
            AND: r = x & y;
            OR:  r = x | y;
            SLL: begin
                r   = x << sh;
                lat = sh + 1;
            end
            SRL: begin
                r   = x >> sh;
                lat = sh + 1;
            end
            default: begin
`ifdef ALU_MUL_EN
                p   = {32'd0, x} * {32'd0, y};
                r   = p[31:0];
                ov  = (p[63:32] != 32'd0);
                lat = 33;
`else
                p   = '0;
                e   = 1'b1;
`endif
            end
        endcase
        st = {(r == 32'd0), r[31], ov};
    endfunction

    // Issue one op at the current negedge and follow it to its done cycle.
    // poke>0 raises an ADD start during cycle T+poke (must be ignored).
    task automatic run_op(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                          input int poke, input string tag);
        logic [31:0] er;
        logic [2:0]  es;
        logic        ee;
        int          lat;
        model(op, x, y, er, es, ee, lat);
        start = 1'b1;
        gin   = op;
        a     = x;
        b     = y;
        @(posedge clk);
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (k == 1 || k == poke + 1) start = 1'b0;
            check({tag, " busy"}, 64'(busy), 64'(k < lat));
            check({tag, " done"}, 64'(done), 64'(k == lat));
            if (k < lat) check({tag, " held"}, 64'(sum), 64'(prev_sum));
            if (k == poke) begin
                start = 1'b1;
                gin   = ADD;
                a     = 32'd1;
                b     = 32'd1;
            end
        end
        check({tag, " sum"}, 64'(sum), 64'(er));
        check({tag, " status"}, 64'(status), 64'(es));
        check({tag, " err"}, 64'(err), 64'(ee));
        prev_sum = er;
    endtask

    initial begin
        logic [2:0]  rop;
        logic [31:0] rx;
        logic [31:0] ry;

        reset = 1'b1;
        start = 1'b0;
        gin   = 3'b000;
        a     = '0;
        b     = '0;
        repeat (2) @(negedge clk);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst sum", 64'(sum), 64'd0);
        check("rst status", 64'(status), 64'd0);
        check("rst err", 64'(err), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Signed overflow on ADD, then SUB issued in the done cycle
        run_op(ADD, 32'h7FFF_FFFF, 32'd1, 0, "add_ovf");
        check("add_ovf lit", 64'({sum, status}), 64'({32'h8000_0000, 3'b011}));
        run_op(SUB, 32'd5, 32'd5, 0, "sub_zero");
        check("sub_zero lit", 64'({sum, status}), 64'({32'd0, 3'b100}));

        run_op(SLT, 32'h8000_0000, 32'd1, 0, "slt_neg");
        check("slt_neg lit", 64'(sum), 64'd1);
        run_op(SLT, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 0, "slt_pos");
        check("slt_pos lit", 64'(sum), 64'd0);
        run_op(SUB, 32'h8000_0000, 32'd1, 0, "sub_ovf");
        check("sub_ovf lit", 64'({sum, status}), 64'({32'h7FFF_FFFF, 3'b001}));

        // Long shift with an ignored start mid-flight, then no stray done
        run_op(SLL, 32'd1, 32'd31, 5, "sll31");
        check("sll31 lit", 64'({sum, status}), 64'({32'h8000_0000, 3'b010}));
        @(negedge clk);
        check("sll31 no extra done", 64'(done), 64'd0);
        check("sll31 idle", 64'(busy), 64'd0);
        run_op(SRL, 32'h8000_0000, 32'h23, 0, "srl3");
        check("srl3 lit", 64'(sum), 64'h1000_0000);
        run_op(SLL, 32'hDEAD_BEEF, 32'h40, 0, "sll0");

        run_op(MUL, 32'h0001_0000, 32'h0001_0000, 0, "mul_big");
        run_op(MUL, 32'd7, 32'd6, 0, "mul_small");
`ifdef ALU_MUL_EN
        check("mul_small lit", 64'({sum, status}), 64'({32'd42, 3'b000}));
`else
        check("mul_ill lit", 64'({sum, status, err}), 64'({32'd0, 3'b100, 1'b1}));
`endif

        // Reset mid-shift, with a start coincident with reset
        start = 1'b1;
        gin   = SLL;
        a     = 32'd1;
        b     = 32'd20;
        @(posedge clk);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            start = 1'b0;
            check("rstmid busy", 64'(busy), 64'd1);
        end
        reset = 1'b1;
        start = 1'b1;
        gin   = OR;
        a     = 32'hF0;
        b     = 32'h0F;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check("rstmid busy0", 64'(busy), 64'd0);
        check("rstmid done0", 64'(done), 64'd0);
        check("rstmid sum", 64'(sum), 64'd0);
        check("rstmid status", 64'(status), 64'd0);
        check("rstmid err", 64'(err), 64'd0);
        prev_sum = '0;
        for (int k = 0; k < 25; k++) begin
            @(negedge clk);
            check("rstmid quiet", 64'({busy, done}), 64'd0);
        end
        run_op(OR, 32'hF0, 32'h0F, 0, "or_after_rst");
        check("or lit", 64'(sum), 64'hFF);

        // Randomized ops, biased toward sign-boundary operands
        for (int i = 0; i < 60; i++) begin
            rop = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 4))
                0:       rx = 32'h8000_0000;
                1:       rx = 32'h7FFF_FFFF;
                2:       rx = 32'hFFFF_FFFF;
                default: rx = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0:       ry = 32'h0000_0001;
                1:       ry = 32'($urandom_range(0, 65535));
                default: ry = $urandom;
            endcase
            run_op(rop, rx, ry, 0, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised multi-cycle ALU for the datapath's execute stage, replacing the purely combinational 32-bit ALU. It keeps the existing 3-bit ALU-control encoding and the zero/negative/overflow status triple, adds logical right shift and an optional iterative multiply, corrects signed overflow and less-than for subtraction, and registers all results. A start/done handshake lets the controller stall on multi-cycle operations.

## Interface
- WIDTH, 32, operand/result width; power of two, ≥ 8. SHW = log2(WIDTH) is the shift-amount width.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request; accepted only when busy=0
- gin  in  3  ALU control line, sampled at accept
- a  in  WIDTH  operand A, sampled at accept
- b  in  WIDTH  operand B, sampled at accept
- busy  out  1  multi-cycle operation in progress
- done  out  1  one-cycle pulse; result/status valid
- sum  out  WIDTH  registered result; held until next done
- status  out  3  [2] zero, [1] negative, [0] overflow; held with sum
- err  out  1  illegal op for the last completed operation; held with sum

## Operation
- Encodings: 010 ADD, 110 SUB, 111 SLT, 000 AND, 001 OR, 101 SLL, 100 SRL (logical), 011 MUL.
- Single-cycle ops: ADD, SUB, SLT, AND, OR. SLT is signed: sum = 1 when (a−b)[W−1] XOR ovf_sub, else 0.
- Shifts: amt = b[SHW−1:0], with upper bits of b ignored. The accumulator loads a and shifts one bit per RUN cycle until the count reaches 0.
- MUL: unsigned shift-add over WIDTH iterations with a 2·WIDTH accumulator. sum = low WIDTH bits of the product.
- Status is computed from the final sum at completion:
  - zero = (sum==0)
  - negative = sum[W−1]
  - overflow:
    - ADD: a,b same sign and sum sign differs.
    - SUB: a,b differ in sign and sum sign differs from a.
    - MUL: high half of product ≠ 0.
    - All other ops: 0.
- err=1 only for an illegal code (see Configuration). In that case sum=0 and status=3'b100.
- FSM:
  - IDLE: start accepted. Single-cycle op → result registered, stays IDLE. Shift with amt=0 → stays IDLE. Otherwise → RUN.
  - RUN: iterate. On the last iteration → register result, assert done, → IDLE.
- start while busy=1 is ignored, with no effect on the in-flight op or its operands.
- Operand inputs are don't-care after accept.

## Timing
- Accept at cycle T. done pulses at T+L, where:
  - L = 1 for single-cycle and illegal ops.
  - L = amt+1 for shifts (amt=0 gives L=1).
  - L = WIDTH+1 for MUL.
- busy is high during cycles T+1 … T+L−1 and low when done is high. A new start is accepted in the done cycle, so single-cycle ops sustain one op per clock.
- sum/status/err update only on the cycle done is asserted.
- Reset (including mid-operation) forces, next edge:
  - FSM → IDLE, in-flight op discarded, no done pulse.
  - sum=0, status=3'b000, err=0, busy=0, done=0.
- start coincident with reset is ignored.

## Configuration
- ALU_MUL_EN defined: code 011 performs the iterative multiply described above.
- ALU_MUL_EN undefined: no multiplier or 2·WIDTH accumulator is built. Code 011 is illegal and completes with L=1, sum=0, status=3'b100, err=1.
- All other codes are legal in both builds.

## Test plan
- ADD a=0x7FFFFFFF, b=1 → done at T+1, sum=0x80000000, status=3'b011, err=0. Then back-to-back SUB a=5, b=5 in the done cycle → done at T+2, sum=0, status=3'b100.
- SLT a=0x80000000, b=1 → sum=1. SLT a=0x7FFFFFFF, b=0xFFFFFFFF → sum=0. SUB a=0x80000000, b=1 → sum=0x7FFFFFFF, status=3'b001.
- SLL a=1, b=31 → busy T+1..T+31, done T+32, sum=0x80000000, status=3'b010. A start with ADD at T+5 is ignored (no extra done). SRL a=0x80000000, b=0x23 (amt=3) → sum=0x10000000, done T+4.
- With ALU_MUL_EN: MUL a=0x10000, b=0x10000 → done T+33, sum=0, status=3'b101. MUL a=7, b=6 → sum=42, status=3'b000. Without ALU_MUL_EN: MUL → done T+1, sum=0, status=3'b100, err=1.
- Reset at T+10 of an SLL amt=20 → next cycle busy=0, done=0, sum=0, status=0, err=0. No done pulse follows. A subsequent OR a=0xF0, b=0x0F → sum=0xFF at T'+1.
